im_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the byte-wide instruction memory (IM). Drives one byte read per cycle to

---
 rtl/im_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_im_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: byte-serial instruction fetch sequencer; assembles big-endian 32-bit words from IM,
// hands them to decode on valid/ready, and owns the PC (sequential wrap, redirect, sticky fault).
module im_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  localparam logic [31:0] WRAP_PC = 32'(MEM_BYTES);
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc_inc, mem_addr_n, instr_n, instr_pc_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] byte_sel;
  logic mem_rd_n, instr_valid_n, fault_n, busy_n, legal;
  assign legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
  assign pc_inc = (pc + 32'd4 == WRAP_PC) ? 32'd0 : pc + 32'd4;
  assign byte_sel = 2'(cnt - 3'd1);
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    mem_rd_n = mem_rd;
    mem_addr_n = mem_addr;
    instr_valid_n = instr_valid;
    instr_n = instr;
    instr_pc_n = instr_pc;
    fault_n = fault;
    if (state != IDLE && redirect_valid) begin
      instr_valid_n = 1'b0;
      mem_rd_n = 1'b0;
      state_n = legal ? FETCH : FAULT;
      fault_n = !legal;
      pc_n = legal ? redirect_pc : pc;
      cnt_n = legal ? 3'd0 : cnt;
    end else begin
      case (state)
        IDLE: begin
          state_n = FETCH;
          cnt_n = 3'd0;
          mem_rd_n = 1'b1;
          mem_addr_n = pc;
        end
        FETCH: begin
          // cnt==0 without a read in flight is the bubble after a redirect: start F0 here
          if (cnt == 3'd0 && !mem_rd) begin
            mem_rd_n = 1'b1;
            mem_addr_n = pc;
          end else begin
            cnt_n = cnt + 3'd1;
            if (cnt != 3'd0) instr_n[{~byte_sel, 3'b000} +: 8] = mem_data;
            mem_rd_n = cnt < 3'd3;
            mem_addr_n = (cnt < 3'd3) ? pc + 32'(cnt) + 32'd1 : mem_addr;
            if (cnt == 3'd4) begin
              state_n = HOLD;
              cnt_n = 3'd0;
              instr_valid_n = 1'b1;
              instr_pc_n = pc;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_n = 1'b0;
            pc_n = pc_inc;
            state_n = FETCH;
            cnt_n = 3'd0;
            mem_rd_n = 1'b1;
            mem_addr_n = pc_inc;
          end
        end
        default: ;
      endcase
    end
    busy_n = state_n == FETCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      cnt <= 3'd0;
      mem_rd <= 1'b0;
      mem_addr <= 32'd0;
      instr_valid <= 1'b0;
      instr <= 32'd0;
      instr_pc <= 32'd0;
      fault <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
      mem_rd <= mem_rd_n;
      mem_addr <= mem_addr_n;
      instr_valid <= instr_valid_n;
      instr <= instr_n;
      instr_pc <= instr_pc_n;
      fault <= fault_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: vector tables for cycle timing and redirect legality, plus a transfer
// scoreboard fed with expected {instr, pc} pairs and drained by a handshake monitor.
module tb_im_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_rd, instr_valid, instr_ready = 1'b0, fault, busy, redirect_valid = 1'b0;
  logic [31:0] mem_addr, instr, instr_pc, redirect_pc = 32'd0;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] mem [32];
  int n_chk = 0, n_err = 0, xfers = 0;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} exp_t;
  typedef struct {logic ready; logic rd; logic [31:0] addr; logic valid;} vec_t;
  typedef struct {logic [31:0] pc; logic flt;} rdr_t;
  exp_t q[$];
  vec_t tv[7];
  rdr_t rv[7];
  im_fetch_ctrl #(.RESET_PC(32'd0), .MEM_BYTES(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fault(fault), .busy(busy)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 32; i++) mem[i] = 8'(i);
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr[4:0]] : 8'hEE;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      xfers++;
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_xfer: got instr=%h pc=%h, none expected", instr, instr_pc);
      end else begin
        e = q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc) begin
          n_err++;
          $display("FAIL xfer: got instr=%h pc=%h expected instr=%h pc=%h", instr, instr_pc, e.instr, e.pc);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] pc);
    logic [7:0] b;
    b = pc[7:0];
    q.push_back('{instr: {b, b + 8'd1, b + 8'd2, b + 8'd3}, pc: pc});
  endtask
  task automatic wait_q();
    for (int i = 0; i < 300 && q.size() != 0; i++) cyc();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 30 && !instr_valid; i++) cyc();
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask
  task automatic wait_addr(input logic [31:0] a);
    for (int i = 0; i < 30 && !(mem_rd && mem_addr == a); i++) cyc();
    chk("addr_timeout", mem_addr, a);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b1, 32'd0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 32'd1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 32'd2, 1'b0};
    tv[3] = '{1'b1, 1'b1, 32'd3, 1'b0};
    tv[4] = '{1'b1, 1'b0, 32'd3, 1'b0};
    tv[5] = '{1'b1, 1'b0, 32'd3, 1'b1};
    tv[6] = '{1'b0, 1'b1, 32'd4, 1'b0};
    rv[0] = '{32'h20, 1'b1};
    rv[1] = '{32'h1D, 1'b1};
    rv[2] = '{32'hFFFF_FFFC, 1'b1};
    rv[3] = '{32'h1C, 1'b0};
    rv[4] = '{32'h22, 1'b1};
    rv[5] = '{32'h0C, 1'b0};
    rv[6] = '{32'h08, 1'b0};
    cyc();
    cyc();
    chk_reset("reset");
    push(32'd0);
    push(32'd4);
    instr_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("t1_rd_c%0d", i + 1), {31'd0, mem_rd}, {31'd0, tv[i].rd});
      chk($sformatf("t1_addr_c%0d", i + 1), mem_addr, tv[i].addr);
      chk($sformatf("t1_valid_c%0d", i + 1), {31'd0, instr_valid}, {31'd0, tv[i].valid});
      if (tv[i].valid) chk("t1_busy_hold", {31'd0, busy}, 32'd0);
      instr_ready = tv[i].ready;
    end
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("t2_instr", instr, 32'h04050607);
      chk("t2_pc", instr_pc, 32'd4);
      chk("t2_rd", {31'd0, mem_rd}, 32'd0);
      chk("t2_valid", {31'd0, instr_valid}, 32'd1);
      cyc();
    end
    instr_ready = 1'b1;
    cyc();
    chk("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("t2_next_addr", mem_addr, 32'd8);
    chk("t2_xfers", 32'(xfers), 32'd2);
    for (int p = 8; p <= 28; p += 4) push(32'(p));
    wait_q();
    chk("t3_wrap_addr", mem_addr, 32'd0);
    push(32'd0);
    wait_q();
    instr_ready = 1'b0;
    redirect_pc = 32'd0;
    redirect_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_bubble_rd", {31'd0, mem_rd}, 32'd0);
    wait_addr(32'd2);
    redirect_pc = 32'h10;
    redirect_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_abort_rd", {31'd0, mem_rd}, 32'd0);
    chk("t4_abort_valid", {31'd0, instr_valid}, 32'd0);
    push(32'h10);
    instr_ready = 1'b1;
    wait_q();
    instr_ready = 1'b0;
    wait_valid();
    chk("drop_instr", instr, 32'h14151617);
    begin
      int x0;
      x0 = xfers;
      instr_ready = 1'b1;
      redirect_pc = 32'h08;
      redirect_valid = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      chk("drop_valid", {31'd0, instr_valid}, 32'd0);
      chk("drop_no_xfer", 32'(xfers), 32'(x0));
    end
    redirect_pc = 32'h0E;
    redirect_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_fault", {31'd0, fault}, 32'd1);
      chk("t5_no_rd", {31'd0, mem_rd}, 32'd0);
      chk("t5_no_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
    end
    for (int i = 0; i < 7; i++) begin
      redirect_pc = rv[i].pc;
      redirect_valid = 1'b1;
      cyc();
      chk($sformatf("t5_fault_%h", rv[i].pc), {31'd0, fault}, {31'd0, rv[i].flt});
      chk($sformatf("t5_busy_%h", rv[i].pc), {31'd0, busy}, {31'd0, !rv[i].flt});
      chk($sformatf("t5_rd_%h", rv[i].pc), {31'd0, mem_rd}, 32'd0);
    end
    redirect_valid = 1'b0;
    push(32'h08);
    instr_ready = 1'b1;
    wait_q();
    wait_addr(32'h0E);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_async");
    cyc();
    rst_n = 1'b1;
    redirect_pc = 32'h10;
    redirect_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    chk("t6_idle_redirect_ignored", mem_addr, 32'd0);
    chk("t6_restart_rd", {31'd0, mem_rd}, 32'd1);
    push(32'd0);
    wait_q();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
